// File: rtl/compare_stim_gen_if.sv
// Comparator port bundle between compare_stim_gen (master) and the
// equality block under test (slave).
//
// Handshake: there is no valid/ready pair. The master holds a/b stable from
// the cycle after it drives them until it samples equal_in. The slave answers
// combinationally (or within the configured settle time) on equal_in.
interface compare_stim_gen_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             equal_in;

  modport master (output a, output b, input equal_in);
  modport slave  (input a, input b, output equal_in);
endinterface

// File: rtl/compare_stim_gen.sv
// Self-checking stimulus sequencer for the compare equality block.
// Sweeps every (a, b) pair with idx ascending (a = low half, b = high half).
// After each pair settles it checks equal_in against a == b, counts the
// mismatches and remembers the first failing pair.
// Optional build macro COMPARE_STIM_STOP_ON_ERR_EN: the first mismatch ends
// the sweep immediately.
module compare_stim_gen #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  compare_stim_gen_if.master    cmp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [WIDTH-1:0]      fail_a,
  output logic [WIDTH-1:0]      fail_b,
  output logic [1:0]            dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  // Last settle count; only used when SETTLE > 0, so the SETTLE = 0 case is a
  // don't-care.
  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [15:0]        err_q, err_d;
  logic [WIDTH-1:0]   fa_q, fa_d, fb_q, fb_d;
  logic               mismatch;
  logic               last_pair;

  // Next-state logic for the sweep sequencer and its result registers.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    fa_d      = fa_q;
    fb_d      = fb_q;
    mismatch  = 1'b0;
    last_pair = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a_d     = idx_q[WIDTH-1:0];
        b_d     = idx_q[2*WIDTH-1:WIDTH];
        cnt_d   = '0;
        state_d = (SETTLE > 0) ? S_WAIT : S_CHECK;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        mismatch = (cmp.equal_in != (a_q == b_q));
        if (mismatch) begin
          err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          if (err_q == 16'd0) begin
            fa_d = a_q;
            fb_d = b_q;
          end
        end
        last_pair = &idx_q;
`ifdef COMPARE_STIM_STOP_ON_ERR_EN
        last_pair = last_pair | mismatch;
`endif
        if (last_pair) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == 16'd0) && !mismatch;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sweep with no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign cmp.a       = a_q;
  assign cmp.b       = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_q;
  assign fail_a      = fa_q;
  assign fail_b      = fb_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_compare_stim_gen.sv
// Bench for compare_stim_gen: two instances (WIDTH=1/SETTLE=1 and
// WIDTH=2/SETTLE=0), each fed by a table-driven comparator whose answers can
// be correct, stuck or randomly corrupted. Expected results come from a
// pair-list model of the sweep.
module tb_compare_stim_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT wiring ----------------
  logic        start_s [2];
  logic [15:0] resp    [2];
  logic        o_busy  [2];
  logic        o_done  [2];
  logic        o_pass  [2];
  logic [15:0] o_err   [2];
  logic [1:0]  o_a     [2];
  logic [1:0]  o_b     [2];
  logic [1:0]  o_fa    [2];
  logic [1:0]  o_fb    [2];
  logic [0:0]  fa0, fb0;
  logic [1:0]  st0, st1;

  compare_stim_gen_if #(.WIDTH(1)) if0 ();
  compare_stim_gen_if #(.WIDTH(2)) if1 ();

  assign if0.equal_in = resp[0][{if0.b, if0.a}];
  assign if1.equal_in = resp[1][{if1.b, if1.a}];

  compare_stim_gen #(.WIDTH(1), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .cmp(if0.master),
    .busy(o_busy[0]), .done(o_done[0]), .pass(o_pass[0]), .err_cnt(o_err[0]),
    .fail_a(fa0), .fail_b(fb0), .dbg_state_o(st0)
  );

  compare_stim_gen #(.WIDTH(2), .SETTLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .cmp(if1.master),
    .busy(o_busy[1]), .done(o_done[1]), .pass(o_pass[1]), .err_cnt(o_err[1]),
    .fail_a(o_fa[1]), .fail_b(o_fb[1]), .dbg_state_o(st1)
  );

  assign o_a[0]  = {1'b0, if0.a};
  assign o_b[0]  = {1'b0, if0.b};
  assign o_a[1]  = if1.a;
  assign o_b[1]  = if1.b;
  assign o_fa[0] = {1'b0, fa0};
  assign o_fb[0] = {1'b0, fb0};

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // mode 0: correct, 1: stuck 0, 2: stuck 1, 3: correct with random flips
  task automatic set_resp(input int d, input int mode);
    int w, n;
    w = width_of(d);
    n = 1 << (2 * w);
    resp[d] = '0;
    for (int i = 0; i < n; i++) begin
      int  pa, pb;
      logic eq;
      pa = i & ((1 << w) - 1);
      pb = i >> w;
      eq = (pa == pb);
      case (mode)
        0: resp[d][i] = eq;
        1: resp[d][i] = 1'b0;
        2: resp[d][i] = 1'b1;
        default: resp[d][i] = eq ^ ($urandom_range(0, 3) == 0);
      endcase
    end
  endtask

  task automatic check_outputs(input string tag, input int d, input int busy_e,
                               input int done_e, input int pass_e, input int err_e,
                               input int fa_e, input int fb_e);
    check({tag, "_busy"}, o_busy[d], busy_e);
    check({tag, "_done"}, o_done[d], done_e);
    check({tag, "_pass"}, o_pass[d], pass_e);
    check({tag, "_err"},  o_err[d],  err_e);
    check({tag, "_fa"},   o_fa[d],   fa_e);
    check({tag, "_fb"},   o_fb[d],   fb_e);
  endtask

  // Caller raises start_s[d] just after a rising edge; the next edge samples it.
  task automatic run_sweep(input int d, input bit hold, input bit noise);
    int w, s, n, per, errs, efa, efb, last, done_edge;
    logic [3:0] cur;
    w = width_of(d);
    s = settle_of(d);
    n = 1 << (2 * w);
    per = s + 2;
    errs = 0; efa = 0; efb = 0; last = n - 1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      int pa, pb;
      pa = i & ((1 << w) - 1);
      pb = i >> w;
      exp_q.push_back(4'(i));
      if (resp[d][i] != (pa == pb)) begin
        if (errs == 0) begin
          efa = pa;
          efb = pb;
        end
        errs++;
`ifdef COMPARE_STIM_STOP_ON_ERR_EN
        last = i;
        break;
`endif
      end
    end
    done_edge = (last + 1) * per;

    @(posedge clk); #1;
    check_outputs($sformatf("d%0d_start", d), d, 1, 0, 0, 0, 0, 0);
    if (!hold) start_s[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;

    cur = '0;
    for (int k = 1; k <= done_edge; k++) begin
      @(posedge clk); #1;
      if ((k - 1) % per == 0) begin
        if (exp_q.size() == 0) check($sformatf("d%0d_pairs_exhausted", d), 1, 0);
        else cur = exp_q.pop_front();
      end
      check($sformatf("d%0d_a_k%0d", d, k), o_a[d], cur & ((1 << w) - 1));
      check($sformatf("d%0d_b_k%0d", d, k), o_b[d], cur >> w);
      check($sformatf("d%0d_busy_k%0d", d, k), o_busy[d], (k < done_edge) ? 1 : 0);
      check($sformatf("d%0d_done_k%0d", d, k), o_done[d], (k == done_edge) ? 1 : 0);
      if (k < done_edge && noise) start_s[d] = 1'($urandom_range(0, 1));
      else start_s[d] = hold;
    end
    check($sformatf("d%0d_pairs_left", d), exp_q.size(), 0);
    check($sformatf("d%0d_end_pass", d), o_pass[d], (errs == 0) ? 1 : 0);
    check($sformatf("d%0d_end_err", d),  o_err[d],  errs);
    check($sformatf("d%0d_end_fa", d),   o_fa[d],   efa);
    check($sformatf("d%0d_end_fb", d),   o_fb[d],   efb);

    if (!hold) begin
      @(posedge clk); #1;
      check_outputs($sformatf("d%0d_idle", d), d, 0, 0, (errs == 0) ? 1 : 0, errs, efa, efb);
      check($sformatf("d%0d_idle_a", d), o_a[d], cur & ((1 << w) - 1));
      check($sformatf("d%0d_idle_b", d), o_b[d], cur >> w);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    set_resp(0, 0);
    set_resp(1, 0);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_outputs($sformatf("rst_d%0d", d), d, 0, 0, 0, 0, 0, 0);
      check($sformatf("rst_d%0d_a", d), o_a[d], 0);
      check($sformatf("rst_d%0d_b", d), o_b[d], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct comparator, single-cycle start.
    start_s[0] = 1'b1;
    run_sweep(0, 0, 0);

    // Stuck-at-0 and stuck-at-1 comparators.
    set_resp(0, 1);
    start_s[0] = 1'b1;
    run_sweep(0, 0, 0);
    set_resp(0, 2);
    start_s[0] = 1'b1;
    run_sweep(0, 0, 0);

    // WIDTH=2, SETTLE=0 with start held: back-to-back sweeps.
    set_resp(1, 0);
    start_s[1] = 1'b1;
    run_sweep(1, 1, 0);
    run_sweep(1, 0, 0);

    // Reset during the third pair aborts the sweep.
    set_resp(0, 0);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_a", o_a[0], 0);
    check("mid_b", o_b[0], 1);
    rst_n = 1'b0;
    #1;
    check_outputs("abort", 0, 0, 0, 0, 0, 0, 0);
    check("abort_a", o_a[0], 0);
    check("abort_b", o_b[0], 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", o_done[0], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    run_sweep(0, 0, 0);

    // Random comparator faults, random start noise while busy.
    repeat (8) begin
      int d;
      d = $urandom_range(0, 1);
      set_resp(d, 3);
      start_s[d] = 1'b1;
      run_sweep(d, 0, 1);
    end

    // Random faults with start held across two sweeps.
    set_resp(1, 3);
    start_s[1] = 1'b1;
    run_sweep(1, 1, 0);
    run_sweep(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
